if_fetch: RTL and testbench

Instruction fetch stage: generates the PC, looks it up in a small direct-mapped instruction cache and, on a miss, assembles the 32-bit instruction from four byte reads over the byte-wide memory-controller port. It sits directly upstream of the IF/ID pipeline register and feeds it one instruction at a time. The cycle it is accepted, if_inst is non-zero; at all other times it is zero (bubble). The block redirects on `branch_interception` and honours `ifid_stall`.

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_fetch_icache.sv | 51 +++++
 rtl/if_fetch.sv | 129 ++++++++++++
 tb/tb_if_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, the
// bubble word, fetch state encodings and a PC alignment helper.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0]      ZERO_WORD  = '0;
    localparam logic [INST_ADDR_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH_LOOKUP = 2'b00,
        FETCH_MEM    = 2'b01,
        FETCH_HOLD   = 2'b10
    } fetch_state_t;

    // Instructions are word aligned, so the two low address bits are dropped.
    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit instruction per line.
// Addressed by word address (PC[31:2]); read is combinational, write is
// synchronous. Only the valid bits are reset; tag and data are not.
module if_fetch_icache
    import if_fetch_pkg::*;
#(
    parameter int ICACHE_LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [29:0]       rd_word,
    output logic              hit,
    output logic [INST_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [29:0]       wr_word,
    input  logic [INST_W-1:0] wr_data
);

    localparam int IW = $clog2(ICACHE_LINES);
    localparam int TW = 30 - IW;

    logic [ICACHE_LINES-1:0] valid;
    logic [TW-1:0]           tag_mem  [ICACHE_LINES];
    logic [INST_W-1:0]       data_mem [ICACHE_LINES];

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;

    assign rd_idx  = rd_word[IW-1:0];
    assign wr_idx  = wr_word[IW-1:0];
    assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_word[29:IW]);
    assign rd_data = data_mem[rd_idx];

    // Valid bits clear on reset so a restarted core begins with a cold cache.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage; a new fill simply overwrites whatever was there.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_word[29:IW];
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage. Looks the PC up in the instruction cache; on a
// miss it assembles the word from four little-endian byte reads, fills the
// cache, and parks the result in a hold register until IF/ID takes it.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                     ICACHE_LINES = 64,
    parameter logic [INST_ADDR_W-1:0] RESET_PC     = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_interception,
    input  logic [INST_ADDR_W-1:0] branch_target,
    input  logic                   ifid_stall,
    output logic                   mem_req,
    output logic [INST_ADDR_W-1:0] mem_addr,
    input  logic                   mem_valid,
    input  logic [7:0]             mem_rdata,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst
);

    fetch_state_t           state;
    logic [INST_ADDR_W-1:0] pc;
    logic [1:0]             byte_cnt;
    logic [23:0]            asm_buf;
    logic [INST_ADDR_W-1:0] hold_pc;
    logic [INST_W-1:0]      hold_inst;

    logic                   cache_hit;
    logic [INST_W-1:0]      cache_data;
    logic                   cache_wr;
    logic [INST_W-1:0]      fill_word;
    logic [29:0]            pc_word;
    logic                   deliver;

    assign pc_word   = pc[INST_ADDR_W-1:2];
    assign fill_word = {mem_rdata, asm_buf};

    // The last byte completes the word; a redirect in that same cycle
    // throws the word away, so the cache must not see it either.
    assign cache_wr = (state == FETCH_MEM) && mem_valid && (byte_cnt == 2'd3)
                      && !branch_interception;

    if_fetch_icache #(
        .ICACHE_LINES (ICACHE_LINES)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_word (pc_word),
        .hit     (cache_hit),
        .rd_data (cache_data),
        .wr_en   (cache_wr),
        .wr_word (pc_word),
        .wr_data (fill_word)
    );

    // Memory request is a pure function of the registered state, so the
    // address holds steady for as long as the controller keeps us waiting.
    assign mem_req  = (state == FETCH_MEM);
    assign mem_addr = mem_req ? {pc[INST_ADDR_W-1:2], byte_cnt} : '0;

    // The held instruction is offered only when IF/ID can take it and no
    // redirect is flushing the pipe; otherwise a bubble goes downstream.
    assign deliver = (state == FETCH_HOLD) && !ifid_stall && !branch_interception;
    assign if_inst = deliver ? hold_inst : ZERO_WORD;
    assign if_pc   = deliver ? hold_pc   : '0;

    // Fetch sequencer: redirect first, then lookup / byte assembly / hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH_LOOKUP;
            pc        <= word_align(RESET_PC);
            byte_cnt  <= 2'd0;
            asm_buf   <= '0;
            hold_pc   <= '0;
            hold_inst <= ZERO_WORD;
        end else if (branch_interception) begin
            pc        <= word_align(branch_target);
            byte_cnt  <= 2'd0;
            hold_pc   <= '0;
            hold_inst <= ZERO_WORD;
            state     <= FETCH_LOOKUP;
        end else begin
            case (state)
                FETCH_LOOKUP: begin
                    if (cache_hit) begin
                        hold_pc   <= pc;
                        hold_inst <= cache_data;
                        pc        <= pc + 32'd4;
                        state     <= FETCH_HOLD;
                    end else begin
                        byte_cnt <= 2'd0;
                        state    <= FETCH_MEM;
                    end
                end
                FETCH_MEM: begin
                    if (mem_valid) begin
                        if (byte_cnt == 2'd3) begin
                            hold_pc   <= pc;
                            hold_inst <= fill_word;
                            pc        <= pc + 32'd4;
                            byte_cnt  <= 2'd0;
                            state     <= FETCH_HOLD;
                        end else begin
                            case (byte_cnt)
                                2'd0:    asm_buf[7:0]   <= mem_rdata;
                                2'd1:    asm_buf[15:8]  <= mem_rdata;
                                default: asm_buf[23:16] <= mem_rdata;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (!ifid_stall) begin
                        hold_pc   <= '0;
                        hold_inst <= ZERO_WORD;
                        state     <= FETCH_LOOKUP;
                    end
                end
                default: begin
                    state <= FETCH_LOOKUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for the fetch stage: a byte-wide memory controller with variable
// wait states, directed scenarios followed by random redirect/stall traffic,
// and a transaction-level model of the expected instruction stream.
module tb_if_fetch;

    localparam int          LINES  = 64;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_interception = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        ifid_stall = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int n_compared   = 0;
    int n_mismatched = 0;

    int   wait_cnt = 0;
    int   wait_lim = 0;
    int   wait_min = 0;
    int   wait_max = 0;
    logic noise_en = 1'b0;
    logic noise    = 1'b0;

    if_fetch #(
        .ICACHE_LINES (LINES),
        .RESET_PC     (RST_PC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .branch_interception (branch_interception),
        .branch_target       (branch_target),
        .ifid_stall          (ifid_stall),
        .mem_req             (mem_req),
        .mem_addr            (mem_addr),
        .mem_valid           (mem_valid),
        .mem_rdata           (mem_rdata),
        .if_pc               (if_pc),
        .if_inst             (if_inst)
    );

    always #5 clk = ~clk;

    // Memory image: word 0 is 32'h00000013, everything else is a hash of the
    // byte address with a non-zero low byte so no word looks like a bubble.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (a[31:2] == 30'd0) begin
            if (a[1:0] == 2'd0) return 8'h13;
            return 8'h00;
        end
        h = a * 32'h9E3779B1;
        if (a[1:0] == 2'd0) return h[31:24] | 8'h01;
        return h[23:16];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        return {mem_byte(wa + 32'd3), mem_byte(wa + 32'd2), mem_byte(wa + 32'd1), mem_byte(wa)};
    endfunction

    // Controller answers after wait_lim idle cycles; with noise_en it also
    // raises stray mem_valid pulses while no request is outstanding.
    always_comb begin
        mem_valid = 1'b0;
        if (mem_req) mem_valid = (wait_cnt >= wait_lim);
        else         mem_valid = noise_en && noise;
    end

    assign mem_rdata = mem_byte(mem_addr);

    // Wait-state counter and per-byte latency selection.
    always @(posedge clk) begin
        noise <= 1'($urandom_range(1, 0));
        if (!mem_req || mem_valid) begin
            wait_cnt <= 0;
            wait_lim <= $urandom_range(wait_max, wait_min);
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic [31:0] t, input logic s);
        @(posedge clk);
        #1;
        branch_interception = b;
        branch_target       = t;
        ifid_stall          = s;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, branch_target, 1'b0);
    endtask

    task automatic waitHandshakes(input int n);
        int seen;
        int budget;
        seen   = 0;
        budget = 200;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (mem_req && mem_valid) seen++;
            budget--;
        end
        if (seen < n) checkOutput("handshake_timeout", 32'(seen), 32'(n));
    endtask

    task automatic waitRequest();
        int budget;
        budget = 200;
        @(negedge clk);
        while (!mem_req && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!mem_req) checkOutput("request_timeout", 32'(mem_req), 32'd1);
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_mem_req"},  32'(mem_req), 32'd0);
        checkOutput({phase, "_mem_addr"}, mem_addr,     32'd0);
        checkOutput({phase, "_if_pc"},    if_pc,        32'd0);
        checkOutput({phase, "_if_inst"},  if_inst,      32'd0);
    endtask

    // Reference model: tracks the PC whose instruction is due next, which
    // word addresses the cache holds, and how many bytes of the current
    // miss have been handed over. A hit is deliverable one cycle after the
    // PC becomes current; a miss is deliverable the cycle after its fourth
    // byte. Outputs are checked mid-cycle, then the model steps to the edge.
    logic [31:0] m_pc;
    int          m_cyc;
    int          m_hs;
    bit          m_done;
    bit          m_cached;
    bit          m_line_v    [LINES];
    logic [29:0] m_line_word [LINES];

    function automatic bit m_hit(input logic [31:0] pc);
        int idx;
        idx = int'(pc[31:2]) % LINES;
        return m_line_v[idx] && (m_line_word[idx] == pc[31:2]);
    endfunction

    initial begin
        bit ready;
        bit exp_req;
        bit exp_del;
        int idx;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_pc     = RST_PC;
                m_cyc    = 0;
                m_hs     = 0;
                m_done   = 1'b0;
                m_cached = 1'b0;
                for (int i = 0; i < LINES; i++) m_line_v[i] = 1'b0;
            end else begin
                if (m_cyc == 0) m_cached = m_hit(m_pc);
                ready   = m_cached ? (m_cyc >= 1) : m_done;
                exp_req = !m_cached && !m_done && (m_cyc >= 1);
                exp_del = ready && !ifid_stall && !branch_interception;

                checkOutput("mem_req", 32'(mem_req), 32'(exp_req));
                if (exp_req) checkOutput("mem_addr", mem_addr, {m_pc[31:2], 2'(m_hs)});
                checkOutput("if_inst", if_inst, exp_del ? mem_word(m_pc) : 32'h0);
                checkOutput("if_pc",   if_pc,   exp_del ? m_pc : 32'h0);

                if (branch_interception) begin
                    m_pc   = branch_target & 32'hFFFF_FFFC;
                    m_cyc  = 0;
                    m_hs   = 0;
                    m_done = 1'b0;
                end else if (exp_del) begin
                    m_pc   = m_pc + 32'd4;
                    m_cyc  = 0;
                    m_hs   = 0;
                    m_done = 1'b0;
                end else begin
                    if (exp_req && mem_valid) begin
                        m_hs++;
                        if (m_hs == 4) begin
                            m_done = 1'b1;
                            idx = int'(m_pc[31:2]) % LINES;
                            m_line_v[idx]    = 1'b1;
                            m_line_word[idx] = m_pc[31:2];
                        end
                    end
                    m_cyc++;
                end
            end
        end
    end

    // Runaway guard.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then random redirect/stall traffic.
    initial begin
        logic        b;
        logic        s;
        logic [31:0] t;
        logic [31:0] bases [4];
        bases[0] = 32'h0000_0000;
        bases[1] = 32'h0000_1000;
        bases[2] = 32'hFFFF_FFC0;
        bases[3] = 32'h0004_0000;

        $display("[TB] reset and cold fetch");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        idleCycles(14);

        $display("[TB] cache hit after branch to 0");
        applyStimulus(1'b1, 32'h0, 1'b0);
        idleCycles(4);

        $display("[TB] stall while holding");
        applyStimulus(1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        idleCycles(4);

        $display("[TB] redirect in the middle of a miss");
        applyStimulus(1'b1, 32'h40, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b0);
        waitHandshakes(2);
        applyStimulus(1'b1, 32'h0000_1002, 1'b0);
        idleCycles(8);
        applyStimulus(1'b1, 32'h40, 1'b0);
        idleCycles(8);

        $display("[TB] slow memory and PC wrap");
        wait_min = 3;
        wait_max = 3;
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        idleCycles(30);

        $display("[TB] reset during a miss");
        applyStimulus(1'b1, 32'h2000, 1'b0);
        applyStimulus(1'b0, 32'h2000, 1'b0);
        waitRequest();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 checkResetOutputs("midreset");
        @(posedge clk);
        #1 rst = 1'b1;
        wait_min = 0;
        wait_max = 0;
        idleCycles(12);

        $display("[TB] random traffic");
        wait_min = 0;
        wait_max = 2;
        noise_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            b = ($urandom_range(15, 0) == 0);
            s = ($urandom_range(3, 0) == 0);
            t = bases[$urandom_range(3, 0)] + 32'($urandom_range(63, 0));
            applyStimulus(b, t, s);
        end
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
